sn_cmd_encoder: RTL

Command-stream transmitter for the SN76489-style sound core: turns register-write requests (3-bit register address plus 10-bit value) into the byte sequence the chip's command receiver decodes, and presents it as a byte plus a one-cycle strobe. It sits between the host/sequencer logic and the receive side, or drives an external SN76489 bus interface. A small FIFO absorbs bursts, and a programmable inter-byte gap meets the receiver's pacing.

---
 rtl/sn_cmd_encoder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sn_cmd_encoder.sv
// sn_cmd_encoder: turns queued register writes (3-bit address, 10-bit value) into
// the SN76489 command byte stream, one byte per single-cycle strobe, with a fixed
// idle gap after every strobe. Tone writes emit a latch byte followed by a data byte.
module sn_cmd_encoder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned GAP   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [9:0] wr_value,
    output logic       wr_ready,
    output logic [7:0] data_out,
    output logic       new_data_out,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
    // Gap counter loads GAP-1 and counts down to zero, so a gap state lasts GAP cycles.
    localparam logic [GW-1:0] GapLoad = (GAP > 0) ? GW'(GAP - 1) : '0;
    localparam logic [AW:0]   Full    = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StGapA,
        StData,
        StGapB
    } state_e;

    logic [12:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    state_e        state;
    logic [2:0]    hold_addr;
    logic [9:0]    hold_value;
    logic [GW-1:0] gap_cnt;
    logic          hold_tone;

    // Ready depends on the registered count only; a same-cycle pop does not free a slot.
    assign wr_ready  = (count != Full);
    assign push      = wr_en && wr_ready;
    assign pop       = (state == StIdle) && (count != '0);
    assign busy      = (count != '0) || (state != StIdle);
    // Tone registers are the even addresses other than the noise register.
    assign hold_tone = !hold_addr[0] && (hold_addr != 3'd6);

    // Request storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {wr_addr, wr_value};
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (wr_en && !wr_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    // Transmit sequencer with registered byte and strobe outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StIdle;
            hold_addr    <= '0;
            hold_value   <= '0;
            gap_cnt      <= '0;
            data_out     <= 8'h00;
            new_data_out <= 1'b0;
        end else begin
            new_data_out <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (pop) begin
                        {hold_addr, hold_value} <= mem[rptr];
                        state <= StLatch;
                    end
                end
                StLatch: begin
                    data_out     <= {1'b1, hold_addr, hold_value[3:0]};
                    new_data_out <= 1'b1;
                    if (GAP > 0) begin
                        gap_cnt <= GapLoad;
                        state   <= StGapA;
                    end else begin
                        state <= hold_tone ? StData : StIdle;
                    end
                end
                StGapA: begin
                    if (gap_cnt == '0) begin
                        state <= hold_tone ? StData : StIdle;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                StData: begin
                    data_out     <= {2'b00, hold_value[9:4]};
                    new_data_out <= 1'b1;
                    if (GAP > 0) begin
                        gap_cnt <= GapLoad;
                        state   <= StGapB;
                    end else begin
                        state <= StIdle;
                    end
                end
                StGapB: begin
                    if (gap_cnt == '0) begin
                        state <= StIdle;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
